// File: rtl/alu_operand_loader.sv
// alu_operand_loader: frames a byte stream into one {opcode, A, B} command
// for the 16-bit ALU. Header byte 0xA<op>, then A lo/hi, then B lo/hi.
// Opcodes 2,3,B,C,E,F are single-operand: their frames stop after A and B
// is issued as zero. A partial frame that stalls for TIMEOUT_CYCLES cycles
// is dropped.
module alu_operand_loader #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  cmd_op,
    output logic [15:0] cmd_a,
    output logic [15:0] cmd_b,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        err_sync,
    output logic        err_timeout,
    output logic [7:0]  frame_count
);

    typedef enum logic [2:0] {
        S_HDR,
        S_A_LO,
        S_A_HI,
        S_B_LO,
        S_B_HI,
        S_ISSUE
    } state_t;

    // The counter value at which one more stalled cycle aborts the frame.
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_stall;
    logic [3:0]  r_cmd_op;
    logic [15:0] r_cmd_a;
    logic [15:0] r_cmd_b;
    logic        r_cmd_valid;
    logic        r_err_sync;
    logic        r_err_timeout;
    logic [7:0]  r_frame_count;

    logic        w_xfer;
    logic        w_short;

    // The loader takes bytes everywhere except while a command waits in ISSUE.
    assign in_ready = (r_state != S_ISSUE);
    assign w_xfer   = in_valid & in_ready;

    // Single-operand opcodes end their frame after the A bytes.
    always_comb begin
        w_short = 1'b0;
        case (r_cmd_op)
            4'h2, 4'h3, 4'hB, 4'hC, 4'hE, 4'hF: w_short = 1'b1;
            default:                            w_short = 1'b0;
        endcase
    end

    // Frame-parsing FSM with stall timeout, command issue and counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_HDR;
            r_stall       <= '0;
            r_cmd_op      <= '0;
            r_cmd_a       <= '0;
            r_cmd_b       <= '0;
            r_cmd_valid   <= 1'b0;
            r_err_sync    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_err_sync    <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                S_HDR: begin
                    r_stall <= '0;
                    if (w_xfer) begin
                        if (in_byte[7:4] == 4'hA) begin
                            r_cmd_op <= in_byte[3:0];
                            r_state  <= S_A_LO;
                        end else begin
                            r_err_sync <= 1'b1;
                        end
                    end
                end
                S_A_LO, S_A_HI, S_B_LO, S_B_HI: begin
                    // A byte arriving on the would-be timeout cycle still wins.
                    if (w_xfer) begin
                        r_stall <= '0;
                        case (r_state)
                            S_A_LO: begin
                                r_cmd_a[7:0] <= in_byte;
                                r_state      <= S_A_HI;
                            end
                            S_A_HI: begin
                                r_cmd_a[15:8] <= in_byte;
                                if (w_short) begin
                                    r_cmd_b     <= '0;
                                    r_cmd_valid <= 1'b1;
                                    r_state     <= S_ISSUE;
                                end else begin
                                    r_state <= S_B_LO;
                                end
                            end
                            S_B_LO: begin
                                r_cmd_b[7:0] <= in_byte;
                                r_state      <= S_B_HI;
                            end
                            default: begin
                                r_cmd_b[15:8] <= in_byte;
                                r_cmd_valid   <= 1'b1;
                                r_state       <= S_ISSUE;
                            end
                        endcase
                    end else if (r_stall == STALL_LAST) begin
                        r_stall       <= '0;
                        r_err_timeout <= 1'b1;
                        r_state       <= S_HDR;
                    end else begin
                        r_stall <= r_stall + 16'd1;
                    end
                end
                S_ISSUE: begin
                    // No timeout here: the ALU may hold off as long as it likes.
                    if (cmd_ready) begin
                        r_cmd_valid   <= 1'b0;
                        r_frame_count <= r_frame_count + 8'd1;
                        r_state       <= S_HDR;
                    end
                end
                default: begin
                    r_cmd_valid <= 1'b0;
                    r_state     <= S_HDR;
                end
            endcase
        end
    end

    assign cmd_op      = r_cmd_op;
    assign cmd_a       = r_cmd_a;
    assign cmd_b       = r_cmd_b;
    assign cmd_valid   = r_cmd_valid;
    assign err_sync    = r_err_sync;
    assign err_timeout = r_err_timeout;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed frames from the test plan followed
// by random traffic, all checked each cycle against a queue-based model.
module tb_alu_operand_loader;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        err_sync;
    logic        err_timeout;
    logic [7:0]  frame_count;

    alu_operand_loader #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .err_sync(err_sync),
        .err_timeout(err_timeout), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: bytes of the frame in progress, a pending command,
    // a stall count and a transfer count.
    logic [7:0]  q[$];
    bit          m_pend;
    int          m_stall;
    int          m_cnt;
    bit          m_sync, m_to;
    logic [3:0]  m_op;
    logic [15:0] m_a, m_b;

    function automatic int flen(input logic [3:0] op);
        if (op inside {4'h2, 4'h3, 4'hB, 4'hC, 4'hE, 4'hF}) return 3;
        return 5;
    endfunction

    task automatic model_clear();
        q.delete();
        m_pend = 0; m_stall = 0; m_cnt = 0; m_sync = 0; m_to = 0;
    endtask

    // Advance the model by one clock edge using the inputs that were applied.
    task automatic model_edge();
        m_sync = 0;
        m_to   = 0;
        if (m_pend) begin
            if (cmd_ready) begin
                m_pend = 0;
                m_cnt  = (m_cnt + 1) % 256;
            end
        end else if (in_valid) begin
            if (q.size() == 0) begin
                if (in_byte[7:4] == 4'hA) q.push_back(in_byte);
                else m_sync = 1;
            end else begin
                q.push_back(in_byte);
                m_stall = 0;
                if (q.size() == flen(q[0][3:0])) begin
                    m_op   = q[0][3:0];
                    m_a    = {q[2], q[1]};
                    m_b    = (q.size() == 5) ? {q[4], q[3]} : 16'h0000;
                    m_pend = 1;
                    q.delete();
                end
            end
        end else if (q.size() > 0) begin
            m_stall++;
            if (m_stall == T) begin
                m_to    = 1;
                m_stall = 0;
                q.delete();
            end
        end
    endtask

    task automatic check_outs();
        chk("in_ready",    32'(in_ready),    32'(!m_pend));
        chk("cmd_valid",   32'(cmd_valid),   32'(m_pend));
        chk("err_sync",    32'(err_sync),    32'(m_sync));
        chk("err_timeout", 32'(err_timeout), 32'(m_to));
        chk("frame_count", 32'(frame_count), 32'(m_cnt));
        if (m_pend) begin
            chk("cmd_op", 32'(cmd_op), 32'(m_op));
            chk("cmd_a",  32'(cmd_a),  32'(m_a));
            chk("cmd_b",  32'(cmd_b),  32'(m_b));
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic r);
        in_valid  = v;
        in_byte   = b;
        cmd_ready = r;
        @(posedge clk);
        model_edge();
        #1 check_outs();
    endtask

    // Assert reset between edges and check outputs drop without a clock.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_in_ready"},  32'(in_ready),    32'h1);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid),   32'h0);
        chk({tag, "_cmd_op"},    32'(cmd_op),      32'h0);
        chk({tag, "_cmd_a"},     32'(cmd_a),       32'h0);
        chk({tag, "_cmd_b"},     32'(cmd_b),       32'h0);
        chk({tag, "_errs"},      32'({err_sync, err_timeout}), 32'h0);
        chk({tag, "_count"},     32'(frame_count), 32'h0);
        model_clear();
        in_valid  = 1'b0;
        cmd_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] bytes5[5];
        rst_n = 1'b1; in_valid = 0; in_byte = 0; cmd_ready = 0;
        model_clear();
        #2 do_reset("rst0");

        // Full ADD frame.
        bytes5 = '{8'hA0, 8'h34, 8'h12, 8'h78, 8'h56};
        foreach (bytes5[i]) step(1, bytes5[i], 1);
        chk("add_valid", 32'(cmd_valid), 32'h1);
        chk("add_a",     32'(cmd_a),     32'h1234);
        chk("add_b",     32'(cmd_b),     32'h5678);
        step(0, 8'h00, 1);
        chk("add_count", 32'(frame_count), 32'h1);
        chk("add_rdy",   32'(in_ready),    32'h1);

        // Short INC frame.
        step(1, 8'hA2, 1); step(1, 8'hFF, 1); step(1, 8'hFF, 1);
        chk("inc_valid", 32'(cmd_valid), 32'h1);
        chk("inc_b",     32'(cmd_b),     32'h0);
        step(0, 8'h00, 1);

        // Backpressure on a SUB frame; offered bytes must be ignored.
        bytes5 = '{8'hA1, 8'h11, 8'h22, 8'h33, 8'h44};
        foreach (bytes5[i]) step(1, bytes5[i], 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 8'($urandom), 0);
            chk("bp_a", 32'(cmd_a), 32'h2211);
        end
        step(0, 8'h00, 1);

        // Sync error then AND frame.
        step(1, 8'h5F, 1);
        chk("sync_pulse", 32'(err_sync), 32'h1);
        bytes5 = '{8'hA8, 8'h01, 8'h02, 8'h03, 8'h04};
        foreach (bytes5[i]) step(1, bytes5[i], 1);
        chk("and_op", 32'(cmd_op), 32'h8);
        step(0, 8'h00, 1);

        // Timeout after T stalled cycles, then a fresh short frame.
        step(1, 8'hA0, 1); step(1, 8'h01, 1);
        for (int i = 0; i < T; i++) step(0, 8'h00, 1);
        chk("to_pulse", 32'(err_timeout), 32'h1);
        step(1, 8'hA3, 1); step(1, 8'h05, 1); step(1, 8'h06, 1);
        chk("to_next_a", 32'(cmd_a), 32'h0605);
        step(0, 8'h00, 1);

        // Byte on the T-th stalled cycle wins over the timeout.
        step(1, 8'hA0, 1); step(1, 8'h01, 1);
        for (int i = 0; i < T - 1; i++) step(0, 8'h00, 1);
        step(1, 8'h02, 1);
        chk("race_no_to", 32'(err_timeout), 32'h0);
        step(1, 8'h03, 1); step(1, 8'h04, 1);
        chk("race_a", 32'(cmd_a), 32'h0201);
        step(0, 8'h00, 1);

        // Reset mid-frame and mid-ISSUE.
        step(1, 8'hA0, 1); step(1, 8'h01, 1);
        do_reset("rst_mid");
        step(1, 8'hA2, 0); step(1, 8'h01, 0); step(1, 8'h02, 0); step(0, 8'h00, 0);
        do_reset("rst_iss");

        // 256 short frames at full rate wrap frame_count back to zero.
        for (int f = 0; f < 256; f++) begin
            step(1, 8'hAB, 1); step(1, 8'(f), 1); step(1, 8'(f ^ 8'h5A), 1);
            step(0, 8'h00, 1);
        end
        chk("wrap_count", 32'(frame_count), 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic       v, r;
            logic [7:0] b;
            v = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) b = 8'($urandom);
            else b = {4'hA, 4'($urandom)};
            step(v, b, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Byte-stream command framer sitting directly upstream of the 16-bit ALU core. It accepts a framed command one byte per transfer over a valid/ready byte interface and assembles the 4-bit opcode and the two 16-bit operands. It then presents them as a single atomic command on a valid/ready command interface that the ALU stage consumes. It also performs sync checking, short-frame handling for single-operand opcodes, stall timeout and command counting.

## Interface
- TIMEOUT_CYCLES, 255, consecutive stalled cycles inside a frame before the frame is aborted; legal range 2..65535.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_byte  in  8  incoming frame byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid & in_ready.
- cmd_op  out  4  assembled opcode.
- cmd_a  out  16  assembled operand A.
- cmd_b  out  16  assembled operand B; 0 for short frames.
- cmd_valid  out  1  command presented.
- cmd_ready  in  1  ALU stage accepts the command; a transfer occurs when cmd_valid & cmd_ready.
- err_sync  out  1  one-cycle pulse: a header byte was discarded.
- err_timeout  out  1  one-cycle pulse: a partial frame was aborted.
- frame_count  out  8  number of commands transferred, modulo 256.

## Operation
- Frame layout:
  - Header byte: [7:4] must be 4'hA; [3:0] is the opcode.
  - Then A[7:0], A[15:8], B[7:0], B[15:8].
- Short frames (header + A lo + A hi only; cmd_b forced to 16'h0000) apply to opcodes 2, 3, B, C, E, F. All other opcodes use full 5-byte frames.
- States and transitions:
  - HDR: on transfer, if in_byte[7:4]==4'hA, latch op and go to A_LO. Otherwise discard the byte, pulse err_sync, stay in HDR.
  - A_LO: latch A[7:0] and go to A_HI.
  - A_HI: latch A[15:8]. Short opcode goes to ISSUE with B cleared; otherwise go to B_LO.
  - B_LO: latch B[7:0] and go to B_HI.
  - B_HI: latch B[15:8] and go to ISSUE.
  - ISSUE: cmd_valid=1, in_ready=0. On cmd_ready: go to HDR and increment frame_count (8'hFF wraps to 8'h00).
- in_ready is 1 in every state except ISSUE.
- Output stability: cmd_op/cmd_a/cmd_b hold their values from entry to ISSUE until the transfer completes, and are not modified while cmd_valid=1. Outside ISSUE their values are don't-care to the consumer but are held registered.
- Stall counter:
  - Counts cycles spent in A_LO, A_HI, B_LO or B_HI with no byte transfer.
  - Clears on every byte transfer and on entry to HDR.
  - Is inactive in HDR and ISSUE; there is no timeout while waiting for cmd_ready.
- Timeout: when the stall counter reaches TIMEOUT_CYCLES, go to HDR, discard the partial fields and pulse err_timeout.
- Simultaneous events: a byte transfer in the cycle the counter would reach TIMEOUT_CYCLES wins; no timeout occurs and the byte is accepted.

## Timing
- Reset values:
  - State HDR, in_ready=1, cmd_valid=0.
  - cmd_op=0, cmd_a=0, cmd_b=0.
  - err_sync=0, err_timeout=0, frame_count=0, stall counter=0.
- Reset mid-frame or mid-ISSUE drops the command immediately and asynchronously; nothing is transferred.
- All outputs are registered except in_ready, which is decoded from the state register.
- Latency: cmd_valid rises on the clock edge that accepts the last frame byte, i.e. it is visible in the next cycle.
- Throughput:
  - Full frame: 5 byte cycles + 1 ISSUE cycle, so 6 cycles per command minimum with cmd_ready held high.
  - Short frame: 4 cycles per command minimum.
- A header byte may be offered in the cycle immediately after the command transfer, since in_ready returns to 1 there.
- err_sync and err_timeout are high for exactly one cycle, in the cycle after the triggering edge.
- frame_count updates on the same edge as the command transfer.

## Test plan
- Full ADD frame: bytes A0,34,12,78,56 back-to-back, cmd_ready=1 -> one cycle of cmd_valid with op=0, a=1234, b=5678; frame_count=1; in_ready=0 for exactly that cycle.
- Short INC frame A2,FF,FF -> cmd_valid with op=2, a=FFFF, b=0000 after 3 byte transfers; B bytes are not awaited.
- Backpressure: full SUB frame A1,… with cmd_ready=0 for 10 cycles -> cmd_valid and cmd_a/cmd_b/cmd_op stable throughout, in_ready=0 throughout, no err_timeout; transfer on the first cycle with cmd_ready=1.
- Sync error: bytes 5F then A8,… -> err_sync pulses once for 5F; the following AND frame is decoded correctly.
- Timeout with TIMEOUT_CYCLES=4:
  - Header A0 and one byte, then in_valid=0 for 4 cycles -> err_timeout pulse, state returns to HDR; next bytes are parsed as a new header.
  - Same setup but a byte arrives on the 4th stalled cycle -> no timeout and the byte is accepted.
- Wrap and reset: 256 short frames -> frame_count returns to 00. Assert rst_n low mid-frame and during ISSUE -> cmd_valid=0 and all outputs at reset values immediately.
